// File: rtl/perceptron_updater_pkg.sv
`default_nettype none
// ============================================================================
// Module  : perceptron_updater_pkg
// Purpose : Shared constants, state encoding and PC-to-row helper for the
//           perceptron training path.
// Revision: 1.0 - initial release
// ============================================================================
package perceptron_updater_pkg;

    localparam int c_ghr_size = 12;
    localparam int c_weight_w = 8;
    localparam int c_hob_w    = 3;
    localparam int c_index_w  = 6;
    localparam int c_theta    = 6;
    localparam int c_sum_w    = 7;
    localparam int c_lob_w    = c_weight_w - c_hob_w;
    localparam int c_row_w    = c_ghr_size * c_weight_w;

    localparam logic [c_weight_w-1:0] c_weight_max = {1'b0, {(c_weight_w-1){1'b1}}};
    localparam logic [c_weight_w-1:0] c_weight_min = {1'b1, {(c_weight_w-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Word-aligned PC; the caller keeps the low index bits.
    function automatic logic [31:0] pc_to_row(input logic [31:0] pc);
        return {2'b00, pc[31:2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/perceptron_weight_sat.sv
`default_nettype none
// ============================================================================
// Module  : perceptron_weight_sat
// Purpose : One weight step (+1/-1) with saturation, plus the HOB, HOB of the
//           saturated negation, and LOB slices of the result.
// Revision: 1.0 - initial release
// ============================================================================
module perceptron_weight_sat
    import perceptron_updater_pkg::*;
#(
    parameter int WEIGHT_W = c_weight_w,
    parameter int HOB_W    = c_hob_w
) (
    input  logic [WEIGHT_W-1:0]       i_w,
    input  logic                      i_inc,
    output logic [WEIGHT_W-1:0]       o_w,
    output logic [HOB_W-1:0]          o_hob,
    output logic [HOB_W-1:0]          o_hob_c,
    output logic [WEIGHT_W-HOB_W-1:0] o_lob
);

    localparam logic [WEIGHT_W-1:0] c_max = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic [WEIGHT_W-1:0] c_min = {1'b1, {(WEIGHT_W-1){1'b0}}};
    localparam logic [WEIGHT_W-1:0] c_one = {{(WEIGHT_W-1){1'b0}}, 1'b1};

    logic [WEIGHT_W-1:0] w_sat;
    logic [WEIGHT_W-1:0] w_neg;

    always_comb begin
        w_sat = i_w;
        if (i_inc) begin
            if (i_w != c_max) begin
                w_sat = i_w + c_one;
            end
        end else begin
            if (i_w != c_min) begin
                w_sat = i_w - c_one;
            end
        end
    end

    // The most negative weight has no positive twin; clamp it to max.
    assign w_neg   = (w_sat == c_min) ? c_max : (~w_sat + c_one);

    assign o_w     = w_sat;
    assign o_hob   = w_sat[WEIGHT_W-1 -: HOB_W];
    assign o_hob_c = w_neg[WEIGHT_W-1 -: HOB_W];
    assign o_lob   = w_sat[WEIGHT_W-HOB_W-1:0];

endmodule
`default_nettype wire

// File: rtl/perceptron_updater.sv
`default_nettype none
// ============================================================================
// Module  : perceptron_updater
// Purpose : Retrains perceptron weight rows from resolved branches (accept,
//           compute, write) after an initial zeroing sweep of the tables.
// Revision: 1.0 - initial release
// ============================================================================
module perceptron_updater
    import perceptron_updater_pkg::*;
#(
    parameter int GHR_SIZE = c_ghr_size,
    parameter int WEIGHT_W = c_weight_w,
    parameter int HOB_W    = c_hob_w,
    parameter int INDEX_W  = c_index_w,
    parameter int THETA    = c_theta,
    parameter int SUM_W    = c_sum_w
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                stall,
    input  logic                                upd_valid,
    output logic                                upd_ready,
    input  logic [31:0]                         upd_pc,
    input  logic                                upd_dir,
    input  logic [SUM_W-1:0]                    upd_sum,
    input  logic [GHR_SIZE-1:0]                 upd_ghr,
    output logic [INDEX_W-1:0]                  rd_addr,
    input  logic [GHR_SIZE*WEIGHT_W-1:0]        rd_data,
    output logic                                wr_en,
    output logic [INDEX_W-1:0]                  wr_addr,
    output logic [GHR_SIZE*WEIGHT_W-1:0]        wr_weights,
    output logic [GHR_SIZE*HOB_W-1:0]           wr_hob,
    output logic [GHR_SIZE*HOB_W-1:0]           wr_hob_c,
    output logic [GHR_SIZE*(WEIGHT_W-HOB_W)-1:0] wr_lob,
    output logic [31:0]                         train_count,
    output logic [31:0]                         skip_count
);

    localparam int c_lw   = WEIGHT_W - HOB_W;
    localparam int c_rw   = GHR_SIZE * WEIGHT_W;
    localparam int c_hw   = GHR_SIZE * HOB_W;
    localparam int c_lobw = GHR_SIZE * c_lw;

    localparam logic [INDEX_W-1:0]     c_last_idx  = {INDEX_W{1'b1}};
    localparam logic signed [SUM_W-1:0] c_theta_pos = SUM_W'(THETA);
    localparam logic signed [SUM_W-1:0] c_theta_neg = SUM_W'(-THETA);

    state_t               r_state;
    logic [INDEX_W-1:0]   r_init_idx;
    logic                 r_init_done;
    logic [INDEX_W-1:0]   r_rd_hold;

    logic                 r_s1_valid;
    logic [INDEX_W-1:0]   r_s1_idx;
    logic                 r_s1_dir;
    logic [SUM_W-1:0]     r_s1_sum;
    logic [GHR_SIZE-1:0]  r_s1_ghr;

    logic                 r_s2_valid;
    logic                 r_s2_train;
    logic [INDEX_W-1:0]   r_s2_idx;
    logic [c_rw-1:0]      r_s2_weights;
    logic [c_hw-1:0]      r_s2_hob;
    logic [c_hw-1:0]      r_s2_hob_c;
    logic [c_lobw-1:0]    r_s2_lob;

    logic                 r_lw_valid;
    logic [INDEX_W-1:0]   r_lw_idx;
    logic [c_rw-1:0]      r_lw_weights;

    logic [31:0]          r_train_count;
    logic [31:0]          r_skip_count;

    logic                 w_run;
    logic                 w_accept;
    logic [31:0]          w_pc_row;
    logic [INDEX_W-1:0]   w_acc_idx;
    logic                 w_s2_pending;
    logic [c_rw-1:0]      w_row_old;
    logic                 w_mispredict;
    logic                 w_low_conf;
    logic                 w_train;
    logic [c_rw-1:0]      w_new_row;
    logic [c_hw-1:0]      w_new_hob;
    logic [c_hw-1:0]      w_new_hob_c;
    logic [c_lobw-1:0]    w_new_lob;

    assign w_run     = (r_state == ST_RUN);
    assign w_accept  = w_run & ~stall & upd_valid;
    assign w_pc_row  = pc_to_row(upd_pc);
    assign w_acc_idx = w_pc_row[INDEX_W-1:0];

    // Holding the address keeps rd_data pointing at the S1 row across stalls.
    assign rd_addr   = w_accept ? w_acc_idx : r_rd_hold;
    assign upd_ready = w_run & ~stall;

    assign w_s2_pending = r_s2_valid & r_s2_train;

    // The RAM returns pre-write data, so the two most recent writes bypass it.
    always_comb begin
        w_row_old = rd_data;
        if (w_s2_pending && (r_s2_idx == r_s1_idx)) begin
            w_row_old = r_s2_weights;
        end else if (r_lw_valid && (r_lw_idx == r_s1_idx)) begin
            w_row_old = r_lw_weights;
        end
    end

    assign w_mispredict = (~r_s1_sum[SUM_W-1]) ^ r_s1_dir;
    assign w_low_conf   = ($signed(r_s1_sum) <= c_theta_pos) &&
                          ($signed(r_s1_sum) >= c_theta_neg);
    assign w_train      = w_mispredict | w_low_conf;

    generate
        for (genvar gi = 0; gi < GHR_SIZE; gi++) begin : g_weight
            perceptron_weight_sat #(
                .WEIGHT_W (WEIGHT_W),
                .HOB_W    (HOB_W)
            ) u_sat (
                .i_w     (w_row_old[gi*WEIGHT_W +: WEIGHT_W]),
                .i_inc   (r_s1_dir == r_s1_ghr[gi]),
                .o_w     (w_new_row[gi*WEIGHT_W +: WEIGHT_W]),
                .o_hob   (w_new_hob[gi*HOB_W +: HOB_W]),
                .o_hob_c (w_new_hob_c[gi*HOB_W +: HOB_W]),
                .o_lob   (w_new_lob[gi*c_lw +: c_lw])
            );
        end
    endgenerate

    // Stall gates only run-time writes; the init sweep ignores it.
    assign wr_en       = w_s2_pending & (~stall | ~w_run);
    assign wr_addr     = r_s2_idx;
    assign wr_weights  = r_s2_weights;
    assign wr_hob      = r_s2_hob;
    assign wr_hob_c    = r_s2_hob_c;
    assign wr_lob      = r_s2_lob;
    assign train_count = r_train_count;
    assign skip_count  = r_skip_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_INIT;
            r_init_idx    <= '0;
            r_init_done   <= 1'b0;
            r_rd_hold     <= '0;
            r_s1_valid    <= 1'b0;
            r_s1_idx      <= '0;
            r_s1_dir      <= 1'b0;
            r_s1_sum      <= '0;
            r_s1_ghr      <= '0;
            r_s2_valid    <= 1'b0;
            r_s2_train    <= 1'b0;
            r_s2_idx      <= '0;
            r_s2_weights  <= '0;
            r_s2_hob      <= '0;
            r_s2_hob_c    <= '0;
            r_s2_lob      <= '0;
            r_lw_valid    <= 1'b0;
            r_lw_idx      <= '0;
            r_lw_weights  <= '0;
            r_train_count <= '0;
            r_skip_count  <= '0;
        end else begin
            r_rd_hold  <= rd_addr;
            r_lw_valid <= wr_en;
            if (wr_en) begin
                r_lw_idx     <= wr_addr;
                r_lw_weights <= wr_weights;
            end

            case (r_state)
                ST_INIT: begin
                    r_s1_valid <= 1'b0;
                    if (r_init_done) begin
                        r_state    <= ST_RUN;
                        r_s2_valid <= 1'b0;
                        r_s2_train <= 1'b0;
                    end else begin
                        r_s2_valid   <= 1'b1;
                        r_s2_train   <= 1'b1;
                        r_s2_idx     <= r_init_idx;
                        r_s2_weights <= '0;
                        r_s2_hob     <= '0;
                        r_s2_hob_c   <= '0;
                        r_s2_lob     <= '0;
                        r_init_idx   <= r_init_idx + INDEX_W'(1);
                        if (r_init_idx == c_last_idx) begin
                            r_init_done <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (!stall) begin
                        r_s1_valid <= w_accept;
                        r_s1_idx   <= w_acc_idx;
                        r_s1_dir   <= upd_dir;
                        r_s1_sum   <= upd_sum;
                        r_s1_ghr   <= upd_ghr;

                        r_s2_valid   <= r_s1_valid;
                        r_s2_train   <= r_s1_valid & w_train;
                        r_s2_idx     <= r_s1_idx;
                        r_s2_weights <= w_new_row;
                        r_s2_hob     <= w_new_hob;
                        r_s2_hob_c   <= w_new_hob_c;
                        r_s2_lob     <= w_new_lob;

                        if (r_s2_valid) begin
                            if (r_s2_train) begin
                                r_train_count <= r_train_count + 32'd1;
                            end else begin
                                r_skip_count <= r_skip_count + 32'd1;
                            end
                        end
                    end
                end

                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perceptron_updater.sv
`default_nettype none
// ============================================================================
// Module  : tb_perceptron_updater
// Purpose : Directed self-checking bench for perceptron_updater with a
//           behavioural sync-read weight RAM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_perceptron_updater;

    logic         clk;
    logic         reset;
    logic         stall;
    logic         upd_valid;
    logic         upd_ready;
    logic [31:0]  upd_pc;
    logic         upd_dir;
    logic [6:0]   upd_sum;
    logic [11:0]  upd_ghr;
    logic [5:0]   rd_addr;
    logic [95:0]  rd_data;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [95:0]  wr_weights;
    logic [35:0]  wr_hob;
    logic [35:0]  wr_hob_c;
    logic [59:0]  wr_lob;
    logic [31:0]  train_count;
    logic [31:0]  skip_count;

    logic [95:0]  r_mem [64];
    logic         r_pl_en;
    logic [5:0]   r_pl_addr;
    logic [95:0]  r_pl_data;

    int n_checks;
    int n_pass;
    int n_fail;
    int n_sweep_ok;

    perceptron_updater u_dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_pc      (upd_pc),
        .upd_dir     (upd_dir),
        .upd_sum     (upd_sum),
        .upd_ghr     (upd_ghr),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_weights  (wr_weights),
        .wr_hob      (wr_hob),
        .wr_hob_c    (wr_hob_c),
        .wr_lob      (wr_lob),
        .train_count (train_count),
        .skip_count  (skip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight store: read returns the old row on a same-cycle write.
    always_ff @(posedge clk) begin
        rd_data <= r_mem[rd_addr];
        if (wr_en)   r_mem[wr_addr]   <= wr_weights;
        if (r_pl_en) r_mem[r_pl_addr] <= r_pl_data;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic d,
                         input logic [6:0] s, input logic [11:0] g);
        upd_valid = v;
        upd_pc    = pc;
        upd_dir   = d;
        upd_sum   = s;
        upd_ghr   = g;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        n_fail     = 0;
        n_sweep_ok = 0;
        reset      = 1'b1;
        stall      = 1'b0;
        r_pl_en    = 1'b0;
        r_pl_addr  = '0;
        r_pl_data  = '0;
        drive(1'b0, 32'h0, 1'b0, 7'h0, 12'h0);

        repeat (3) @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_ready", upd_ready, 0);
        check("rst_train_cnt", train_count, 0);
        check("rst_skip_cnt", skip_count, 0);
        reset = 1'b0;

        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (wr_en === 1'b1 && wr_addr === 6'(k) && wr_weights === '0 &&
                wr_hob === '0 && wr_hob_c === '0 && wr_lob === '0 && upd_ready === 1'b0)
                n_sweep_ok++;
        end
        check("sweep_rows", n_sweep_ok, 64);
        @(negedge clk);
        check("ready_after_sweep", upd_ready, 1);
        check("idle_wr_en", wr_en, 0);
        check("idle_cnt", {train_count, skip_count}, 0);

        // Mispredict from zero row: every weight +1.
        drive(1'b1, 32'h40, 1'b1, 7'h7D, 12'hFFF);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 7'h0, 12'h0);
        @(negedge clk);
        check("t1_wr_en", wr_en, 1);
        check("t1_addr", wr_addr, 16);
        check("t1_weights", wr_weights, {12{8'h01}});
        check("t1_hob", wr_hob, 0);
        check("t1_hob_c", wr_hob_c, {12{3'b111}});
        check("t1_lob", wr_lob, {12{5'h01}});
        @(negedge clk);
        check("t1_wr_done", wr_en, 0);
        check("t1_train_cnt", train_count, 1);

        // Confident correct prediction: no training.
        drive(1'b1, 32'h80, 1'b1, 7'd20, 12'hFFF);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 7'h0, 12'h0);
        @(negedge clk);
        check("t2_no_wr", wr_en, 0);
        @(negedge clk);
        check("t2_skip_cnt", skip_count, 1);
        check("t2_train_cnt", train_count, 1);
        check("t2_row_kept", r_mem[32], 0);

        r_pl_en = 1'b1; r_pl_addr = 6'd8; r_pl_data = {12{8'h7F}};
        @(negedge clk);
        r_pl_addr = 6'd9; r_pl_data = {12{8'h80}};
        @(negedge clk);
        r_pl_en = 1'b0;

        // Positive saturation, low-confidence correct prediction.
        drive(1'b1, 32'h20, 1'b1, 7'd5, 12'hFFF);
        @(negedge clk);
        drive(1'b1, 32'h24, 1'b0, 7'd5, 12'hFFF);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 7'h0, 12'h0);
        check("sat_hi_weights", wr_weights, {12{8'h7F}});
        check("sat_hi_hob", wr_hob, {12{3'b011}});
        check("sat_hi_hob_c", wr_hob_c, {12{3'b100}});
        @(negedge clk);
        check("sat_lo_weights", wr_weights, {12{8'h80}});
        check("sat_lo_hob", wr_hob, {12{3'b100}});
        check("sat_lo_hob_c", wr_hob_c, {12{3'b011}});
        @(negedge clk);
        check("sat_train_cnt", train_count, 3);

        // Back-to-back on the same row: S2 bypass.
        drive(1'b1, 32'h44, 1'b1, 7'h7D, 12'hFFF);
        @(negedge clk);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 7'h0, 12'h0);
        check("b2b_first", wr_weights, {12{8'h01}});
        @(negedge clk);
        check("b2b_second_en", wr_en, 1);
        check("b2b_second", wr_weights, {12{8'h02}});
        check("b2b_addr", wr_addr, 17);

        // One idle cycle between: last-write bypass.
        drive(1'b1, 32'h48, 1'b1, 7'h7D, 12'hFFF);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 7'h0, 12'h0);
        @(negedge clk);
        check("gap_first", wr_weights, {12{8'h01}});
        drive(1'b1, 32'h48, 1'b1, 7'h7D, 12'hFFF);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 7'h0, 12'h0);
        @(negedge clk);
        check("gap_second_en", wr_en, 1);
        check("gap_second", wr_weights, {12{8'h02}});
        @(negedge clk);
        check("gap_train_cnt", train_count, 7);

        // Mixed history: weights agreeing with dir go up, others down.
        drive(1'b1, 32'h4C, 1'b0, 7'd3, 12'h0F0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 7'h0, 12'h0);
        @(negedge clk);
        check("mix_weights", wr_weights, 96'h01010101_FFFFFFFF_01010101);
        check("mix_hob", wr_hob, 36'h000_FFF_000);

        // Stall with a pending write.
        @(negedge clk);
        drive(1'b1, 32'h50, 1'b1, 7'h7D, 12'hFFF);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 7'h0, 12'h0);
        @(negedge clk);
        stall = 1'b1;
        #1;
        check("stall_wr_en0", wr_en, 0);
        @(negedge clk);
        check("stall_wr_en1", wr_en, 0);
        check("stall_ready", upd_ready, 0);
        @(negedge clk);
        check("stall_wr_en2", wr_en, 0);
        check("stall_train_cnt", train_count, 8);
        stall = 1'b0;
        #1;
        check("release_wr_en", wr_en, 1);
        check("release_addr", wr_addr, 20);
        check("release_weights", wr_weights, {12{8'h01}});
        @(negedge clk);
        check("release_once", wr_en, 0);
        check("release_train_cnt", train_count, 9);
        check("release_row", r_mem[20], {12{8'h01}});

        // Reset with a write in flight.
        drive(1'b1, 32'h54, 1'b1, 7'h7D, 12'hFFF);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 7'h0, 12'h0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_ready", upd_ready, 0);
        check("mid_rst_cnt", {train_count, skip_count}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("resweep_en", wr_en, 1);
        check("resweep_addr", wr_addr, 0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perceptron_updater.md
Name: perceptron_updater

Overview:
- Training end of the perceptron branch predictor. Lookup reads weights at fetch; this block retrains them from resolved branches at execute.
- Accepts one resolved branch per cycle. Reads that branch's weight row, applies the perceptron training rule with saturation, and writes the row back.
- Produces the HOB, complemented-HOB and LOB table write data consumed by the predictor tables.
- After reset, sweeps all table rows to zero weight before accepting updates.

Parameters:
- GHR_SIZE, 12, history length = weights per row
- WEIGHT_W, 8, bits per weight (two's complement)
- HOB_W, 3, high-order bits of each weight used by lookup
- INDEX_W, 6, table index width (64 rows, index = PC[INDEX_W+1:2])
- THETA, 6, training threshold on |sum|
- SUM_W, 7, width of lookup-time signed sum

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall  in  1  freeze all pipeline stages; no accept, no write
- upd_valid  in  1  resolved branch present
- upd_ready  out  1  block can accept (low during INIT sweep)
- upd_pc  in  32  branch PC
- upd_dir  in  1  actual direction (1 = taken)
- upd_sum  in  SUM_W  signed sum computed at lookup
- upd_ghr  in  GHR_SIZE  history used at lookup
- rd_addr  out  INDEX_W  full-weight store read address (sync RAM, 1-cycle latency)
- rd_data  in  GHR_SIZE*WEIGHT_W  weight row
- wr_en  out  1  write strobe to weight store and HOB/HOB_c/LOB tables
- wr_addr  out  INDEX_W  write row
- wr_weights  out  GHR_SIZE*WEIGHT_W  full new row
- wr_hob  out  GHR_SIZE*HOB_W  top HOB_W bits of each weight
- wr_hob_c  out  GHR_SIZE*HOB_W  top HOB_W bits of saturated negation of each weight
- wr_lob  out  GHR_SIZE*(WEIGHT_W-HOB_W)  low bits of each weight
- train_count  out  32  rows actually modified
- skip_count  out  32  accepted updates not requiring training

Behaviour:
- Reset (synchronous): state INIT, init index 0; counters 0; pipeline valids 0; wr_en 0; upd_ready 0; forwarding registers invalid.
- INIT: each cycle, wr_en=1, wr_addr=init index, all weights 0, so wr_hob = wr_hob_c = wr_lob = 0. Index increments by 1.
  - After row 2^INDEX_W-1 is written, go to RUN next cycle. The sweep takes exactly 64 cycles.
  - stall is ignored during INIT.
  - Reset asserted mid-sweep restarts the sweep at 0.
- RUN: upd_ready = ~stall. Three stages:
  - S0 (accept): on upd_valid & upd_ready, drive rd_addr = upd_pc[7:2]; register index, dir, sum, ghr.
  - S1 (compute): read row arrives. Select forwarded data (below). Decide train = (sign(sum) != ~dir), i.e. mispredict, OR |sum| <= THETA. Take the taken prediction as sum >= 0. Per weight i: w' = (dir == ghr[i]) ? w+1 : w-1, saturating at +127 / -128. Register the result.
  - S2 (write): if train, pulse wr_en for one cycle with the new row and its HOB/HOB_c/LOB slices, and increment train_count. Otherwise no write and increment skip_count.
- Latency: accept cycle N -> wr_en in cycle N+2.
- Throughput: one update per cycle.
- HOB_c slice: -w with saturation (-(-128) = +127), top HOB_W bits.
- Forwarding (read-before-write hazard; RAM returns old data on same-cycle read/write):
  - If the S1 index matches the S2 index with a pending write, use S2 data.
  - Else, if it matches the row written in the previous cycle (held in a last-write register), use that.
  - Else use rd_data.
  - S2 takes priority over the last-write register.
- stall high:
  - All stage registers hold and wr_en is forced 0.
  - rd_addr holds its value, so rd_data remains valid on release.
  - The held S2 write issues once on the first non-stall cycle.
- Counters wrap at 2^32.

Decomposition:
- Shared package: weight min/max constants, HOB/LOB slice widths, row width, index extraction function, and the state enum {INIT, RUN}.
- One sub-module, perceptron_weight_sat: one weight plus increment/decrement select; outputs saturated w', its HOB, HOB_c and LOB slices. Instantiated GHR_SIZE times in S1.

Test Plan:
- Reset then idle: wr_en high 64 consecutive cycles with addr 0..63 and all data 0. upd_ready rises on cycle 65. Counters 0.
- Single update, pc=0x40, dir=1, sum=-3, ghr=0xFFF, row all 0: wr_en at accept+2, addr 16, every weight = 1, wr_hob = 0, wr_hob_c all 3'b111, train_count=1.
- Confident correct prediction, sum=+20, dir=1: no wr_en, skip_count=1, table unchanged.
- Saturation: row all +127, dir=1, ghr=0xFFF, sum=5 -> weights stay 127 with wr_hob=3'b011. Row all -128, dir=0, ghr=0xFFF -> weights stay -128 with wr_hob_c=3'b011.
- Back-to-back same index: two updates on pc=0x40 in consecutive cycles, each +1 from 0 -> second write carries 2. Repeat with one idle cycle between updates -> also 2, via the last-write register.
- Stall: assert stall for 3 cycles while S2 holds a write -> wr_en stays low; single write on release; no lost or duplicated update. Reset mid-RUN -> in-flight write dropped, INIT sweep restarts.
